// File: rtl/fifo_handshake.sv
// Router input buffer: accepts one flit per RTS/CTS handshake into a circular
// FIFO and presents the head flit first-word fall-through to the crossbar.
module fifo_handshake #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DRTS,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  CTS,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty_out,
  output logic                  full_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         read_ptr;
  logic [PW-1:0]         write_ptr;
  logic [CW-1:0]         count;
  logic                  wr;
  logic                  pop;

  assign empty_out = (count == '0);
  assign full_out  = (count == CW'(DEPTH));

  // Full is judged on pre-pop occupancy, so a write coinciding with a pop
  // from a full FIFO is deferred to a later handshake.
  assign wr  = DRTS & ~CTS & ~full_out;
  assign pop = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) & ~empty_out;

  assign Data_out = mem[read_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      read_ptr  <= '0;
      write_ptr <= '0;
      count     <= '0;
      CTS       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      CTS <= wr;
      if (wr) begin
        mem[write_ptr] <= RX;
        write_ptr      <= write_ptr + PW'(1);
      end
      if (pop) begin
        read_ptr <= read_ptr + PW'(1);
      end
      if (wr && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !wr) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
